// File: rtl/pwm_pkg.sv
// pwm_pkg: shared PWM frame constants, widths and capture FSM encoding
package pwm_pkg;
    localparam int PERIOD_CYCLES_DEF = 1_000_000;
    localparam int MIN_PULSE_DEF = 50_000;
    localparam int MAX_PULSE_DEF = 100_000;
    localparam int DUTY_MAX = 125;
    localparam int DUTY_W = 8;
    localparam int CNT_W = 20;

    typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

    function automatic int step_of(input int min_pulse, input int max_pulse);
        return (max_pulse - min_pulse) / DUTY_MAX;
    endfunction

    localparam int STEP = step_of(MIN_PULSE_DEF, MAX_PULSE_DEF);
endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: 2-FF synchronizer with rise/fall detection on the synchronized line
module pwm_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise,
    output logic fall
);
    logic [2:0] sh;

    // two metastability stages followed by one history stage for edge detection
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sh <= '0;
        else        sh <= {sh[1:0], sig};

    assign rise = sh[1] & ~sh[2];
    assign fall = ~sh[1] & sh[2];
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: servo PWM decoder measuring high time and period with timeout detection
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int PERIOD_CYCLES  = PERIOD_CYCLES_DEF,
    parameter int MIN_PULSE      = MIN_PULSE_DEF,
    parameter int MAX_PULSE      = MAX_PULSE_DEF,
    parameter int PERIOD_TOL     = 50_000,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_valid,
    output logic              pulse_err,
    output logic              period_err,
    output logic              timeout
);
    localparam int STEP_N = step_of(MIN_PULSE, MAX_PULSE);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] PER_LO = CNT_W'(PERIOD_CYCLES - PERIOD_TOL);
    localparam logic [CNT_W-1:0] PER_HI = CNT_W'(PERIOD_CYCLES + PERIOD_TOL);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_N - 1);
    localparam logic [CNT_W-1:0] CNT_TOP = '1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_TOP = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [DUTY_W-1:0] DUTY_TOP = DUTY_W'(DUTY_MAX);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   high_cnt, period_cnt, pre_cnt;
    logic [DUTY_W-1:0]  step_cnt;
    logic [IDLE_W-1:0]  idle_cnt;
    logic               rise, fall, in_range;
    logic               start, done_ok, done_bad, per_bad, to_hit;

    pwm_sync_edge u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .sig  (pwm_in),
        .rise (rise),
        .fall (fall)
    );

    assign in_range = high_cnt >= MIN_C && high_cnt <= MAX_C;

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= WAIT_RISE;
        else        state <= state_nxt;

    // next state and event decode; a rise takes priority over a timeout in the same cycle
    always_comb begin
        state_nxt = state;
        start = 1'b0;
        done_ok = 1'b0;
        done_bad = 1'b0;
        per_bad = 1'b0;
        to_hit = 1'b0;
        if (!en) begin
            state_nxt = WAIT_RISE;
        end else if (rise) begin
            state_nxt = MEAS_HIGH;
            start = 1'b1;
            per_bad = state == MEAS_LOW && (period_cnt < PER_LO || period_cnt > PER_HI);
        end else if (fall) begin
            if (state == MEAS_HIGH) begin
                state_nxt = MEAS_LOW;
                done_ok = in_range;
                done_bad = !in_range;
            end
        end else if (idle_cnt == IDLE_LAST) begin
            state_nxt = WAIT_RISE;
            to_hit = 1'b1;
        end
    end

    // high/period counters and the STEP prescaler that replaces a divider
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            high_cnt <= '0;
            period_cnt <= '0;
            pre_cnt <= '0;
            step_cnt <= '0;
        end else if (!en || to_hit) begin
            high_cnt <= '0;
            period_cnt <= '0;
            pre_cnt <= '0;
            step_cnt <= '0;
        end else if (start) begin
            high_cnt <= CNT_W'(1);
            period_cnt <= CNT_W'(1);
            pre_cnt <= '0;
            step_cnt <= '0;
        end else begin
            if (state != WAIT_RISE && period_cnt != CNT_TOP) period_cnt <= period_cnt + 1'b1;
            if (state == MEAS_HIGH) begin
                if (high_cnt != CNT_TOP) high_cnt <= high_cnt + 1'b1;
                if (high_cnt >= MIN_C) begin
                    pre_cnt <= (pre_cnt == STEP_LAST) ? '0 : pre_cnt + 1'b1;
                    if (pre_cnt == STEP_LAST && step_cnt != DUTY_TOP) step_cnt <= step_cnt + 1'b1;
                end
            end
        end

    // cycles since the last edge, saturating at the timeout threshold
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                     idle_cnt <= '0;
        else if (!en || rise || fall)   idle_cnt <= '0;
        else if (idle_cnt != IDLE_TOP)  idle_cnt <= idle_cnt + 1'b1;

    // registered strobes, held duty and timeout level
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            duty <= '0;
            duty_valid <= 1'b0;
            pulse_err <= 1'b0;
            period_err <= 1'b0;
            timeout <= 1'b0;
        end else begin
            duty_valid <= done_ok;
            pulse_err <= done_bad;
            period_err <= per_bad;
            if (done_ok) duty <= step_cnt;
            timeout <= (!en || rise) ? 1'b0 : to_hit ? 1'b1 : timeout;
        end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench for pwm_capture with a frame-level reference model
module tb_pwm_capture;
    localparam int PER = 2000;
    localparam int TOL = 100;
    localparam int MINP = 250;
    localparam int MAXP = 500;
    localparam int TO = 4000;
    localparam int STEPB = (MAXP - MINP) / 125;

    typedef struct {
        int kind;
        int duty;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, en, pwm_in;
    logic [7:0] duty;
    logic       duty_valid, pulse_err, period_err, timeout;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   have_prev = 0;
    int   prev_p = 0;

    pwm_capture #(
        .PERIOD_CYCLES (PER),
        .MIN_PULSE     (MINP),
        .MAX_PULSE     (MAXP),
        .PERIOD_TOL    (TOL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pwm_in    (pwm_in),
        .duty      (duty),
        .duty_valid(duty_valid),
        .pulse_err (pulse_err),
        .period_err(period_err),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int kind, input int d);
        exp_t e;
        e.kind = kind;
        e.duty = d;
        exp_q.push_back(e);
    endtask

    // a rise closes the previous frame's period if one was being measured
    task automatic model_rise();
        if (have_prev && (prev_p < PER - TOL || prev_p > PER + TOL)) push(2, 0);
    endtask

    task automatic model_fall(input int h);
        int d;
        d = (h - MINP) / STEPB;
        if (h >= MINP && h <= MAXP) push(0, d > 125 ? 125 : d);
        else push(1, 0);
    endtask

    // drives one frame starting at a negedge: high for h cycles, total length p cycles
    task automatic frame(input int h, input int p, input bit mdl);
        if (mdl) begin
            model_rise();
            model_fall(h);
            have_prev = 1;
            prev_p = p;
        end
        pwm_in = 1'b1;
        repeat (10) @(negedge clk);
        check("timeout_low_in_pulse", int'(timeout), 0);
        repeat (h - 10) @(negedge clk);
        pwm_in = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    task automatic observe(input int kind);
        exp_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL strobe: got kind %0d duty %0d, expected no strobe", kind, duty);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == 0 && int'(duty) != e.duty)) begin
                fails++;
                $display("FAIL strobe: got kind %0d duty %0d, expected kind %0d duty %0d", kind, duty, e.kind, e.duty);
            end
        end
    endtask

    // monitor: every strobe the DUT raises is matched against the scoreboard
    always @(negedge clk) begin
        if (duty_valid) observe(0);
        if (pulse_err) observe(1);
        if (period_err) observe(2);
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got no finish after 90000 cycles, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_duty", int'(duty), 0);
        check("rst_duty_valid", int'(duty_valid), 0);
        check("rst_pulse_err", int'(pulse_err), 0);
        check("rst_period_err", int'(period_err), 0);
        check("rst_timeout", int'(timeout), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        frame(250, 2000, 1);
        frame(250, 2000, 1);
        frame(500, 2000, 1);
        frame(375, 2000, 1);
        frame(310, 2000, 1);
        frame(200, 2000, 1);
        frame(600, 2000, 1);
        check("duty_held_after_errs", int'(duty), 30);
        frame(249, 2000, 1);
        frame(501, 2000, 1);
        frame(253, 2000, 1);
        frame(300, 1600, 1);
        frame(300, 2080, 1);
        frame(300, 1900, 1);
        frame(300, 2100, 1);
        frame(300, 1899, 1);
        frame(420, 2000, 1);

        frame(300, 300 + 3800, 1);
        check("timeout_before_limit", int'(timeout), 0);
        repeat (300) @(negedge clk);
        check("timeout_set", int'(timeout), 1);
        check("timeout_duty_held", int'(duty), 25);
        have_prev = 0;
        frame(375, 2000, 1);

        en = 1'b0;
        frame(300, 2000, 0);
        frame(450, 2000, 0);
        check("disabled_duty_held", int'(duty), 62);
        en = 1'b1;
        have_prev = 0;

        for (int i = 0; i < 10; i++)
            frame(int'($urandom_range(200, 560)), int'($urandom_range(1850, 2150)), 1);

        model_rise();
        have_prev = 0;
        pwm_in = 1'b1;
        repeat (150) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_duty", int'(duty), 0);
        check("midrst_duty_valid", int'(duty_valid), 0);
        check("midrst_pulse_err", int'(pulse_err), 0);
        check("midrst_period_err", int'(period_err), 0);
        check("midrst_timeout", int'(timeout), 0);
        @(negedge clk);
        pwm_in = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        frame(375, 2000, 1);
        frame(310, 2000, 1);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
